// File: rtl/dbg_pkg.sv
// Shared state encoding and default sizing for the debug run controller.
package dbg_pkg;

    localparam int unsigned NUM_CH_DEF = 2;
    localparam int unsigned STEP_W_DEF = 8;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        HALT = 2'b01,
        STEP = 2'b10
    } ch_state_e;

endpackage

// File: rtl/dbg_ch_ctrl.sv
// One debug clock channel: run/halt/step FSM, step counter, breakpoint edge detect, clock gate.
module dbg_ch_ctrl
    import dbg_pkg::*;
#(
    parameter int unsigned STEP_W = STEP_W_DEF
) (
    input  logic              sys_clk,
    input  logic              dbg_rst,
    input  logic              halt_req,
    input  logic              resume_req,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_count,
    input  logic              bkpt,
    output logic              dbg_clk,
    output logic              halted,
    output logic              step_done,
    output logic              in_step_c
);

    ch_state_e         state;
    logic [STEP_W-1:0] cnt;
    logic              clk_en;
    logic              gate;
    logic              bkpt_q;
    logic              bkpt_rise;
    logic [STEP_W-1:0] step_load;

    // Breakpoint rising edge; held-high breakpoints do not re-trigger after resume.
    assign bkpt_rise = bkpt & ~bkpt_q;

    // A step count of zero is treated as a single-cycle step.
    assign step_load = (step_count == '0) ? '0 : step_count - STEP_W'(1);

    assign in_step_c = (state == STEP);

    // Channel FSM with registered halted/step_done and the breakpoint history register.
    always_ff @(posedge sys_clk or negedge dbg_rst) begin
        if (!dbg_rst) begin
            state     <= RUN;
            clk_en    <= 1'b1;
            cnt       <= '0;
            bkpt_q    <= 1'b0;
            halted    <= 1'b0;
            step_done <= 1'b0;
        end else begin
            bkpt_q    <= bkpt;
            step_done <= 1'b0;
            case (state)
                RUN: begin
                    if (halt_req || bkpt_rise) begin
                        state  <= HALT;
                        clk_en <= 1'b0;
                        halted <= 1'b1;
                    end
                end
                HALT: begin
                    if (!halt_req) begin
                        if (step_req) begin
                            state  <= STEP;
                            clk_en <= 1'b1;
                            cnt    <= step_load;
                            halted <= 1'b0;
                        end else if (resume_req) begin
                            state  <= RUN;
                            clk_en <= 1'b1;
                            halted <= 1'b0;
                        end
                    end
                end
                STEP: begin
                    if (halt_req) begin
                        state  <= HALT;
                        clk_en <= 1'b0;
                        halted <= 1'b1;
                    end else if (cnt == '0) begin
                        state     <= HALT;
                        clk_en    <= 1'b0;
                        halted    <= 1'b1;
                        step_done <= 1'b1;
                    end else begin
                        cnt <= cnt - STEP_W'(1);
                    end
                end
                default: begin
                    state  <= HALT;
                    clk_en <= 1'b0;
                    halted <= 1'b1;
                end
            endcase
        end
    end

    // Gate enable captured while sys_clk is low so the gated clock never glitches.
    always_ff @(negedge sys_clk or negedge dbg_rst) begin
        if (!dbg_rst) begin
            gate <= 1'b1;
        end else begin
            gate <= clk_en;
        end
    end

    assign dbg_clk = sys_clk & gate;

endmodule

// File: rtl/dbg_run_ctrl.sv
// Debug run controller: fans requests out to per-channel controllers and merges busy.
module dbg_run_ctrl
    import dbg_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEF,
    parameter int unsigned STEP_W = STEP_W_DEF
) (
    input  logic              sys_clk,
    input  logic              dbg_rst,
    input  logic              halt_req,
    input  logic              resume_req,
    input  logic              step_req,
    input  logic [NUM_CH-1:0] ch_sel,
    input  logic [STEP_W-1:0] step_count,
    input  logic [NUM_CH-1:0] bkpt,
    output logic [NUM_CH-1:0] dbg_clk,
    output logic [NUM_CH-1:0] halted,
    output logic [NUM_CH-1:0] step_done,
    output logic              busy
);

    logic [NUM_CH-1:0] in_step;

    // One controller per channel; each request strobe is qualified by its ch_sel bit.
    for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
        dbg_ch_ctrl #(
            .STEP_W (STEP_W)
        ) u_ch (
            .sys_clk    (sys_clk),
            .dbg_rst    (dbg_rst),
            .halt_req   (halt_req   & ch_sel[i]),
            .resume_req (resume_req & ch_sel[i]),
            .step_req   (step_req   & ch_sel[i]),
            .step_count (step_count),
            .bkpt       (bkpt[i]),
            .dbg_clk    (dbg_clk[i]),
            .halted     (halted[i]),
            .step_done  (step_done[i]),
            .in_step_c  (in_step[i])
        );
    end

    assign busy = |in_step;

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Self-checking bench for dbg_run_ctrl using an expected-value scoreboard.
module tb_dbg_run_ctrl;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned STEP_W = 8;

    logic              sys_clk = 1'b0;
    logic              dbg_rst = 1'b0;
    logic              halt_req = 1'b0;
    logic              resume_req = 1'b0;
    logic              step_req = 1'b0;
    logic [NUM_CH-1:0] ch_sel = '0;
    logic [STEP_W-1:0] step_count = '0;
    logic [NUM_CH-1:0] bkpt = '0;
    logic [NUM_CH-1:0] dbg_clk;
    logic [NUM_CH-1:0] halted;
    logic [NUM_CH-1:0] step_done;
    logic              busy;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned ecnt0 = 0;
    int unsigned ecnt1 = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];

    dbg_run_ctrl #(
        .NUM_CH (NUM_CH),
        .STEP_W (STEP_W)
    ) dut (
        .sys_clk    (sys_clk),
        .dbg_rst    (dbg_rst),
        .halt_req   (halt_req),
        .resume_req (resume_req),
        .step_req   (step_req),
        .ch_sel     (ch_sel),
        .step_count (step_count),
        .bkpt       (bkpt),
        .dbg_clk    (dbg_clk),
        .halted     (halted),
        .step_done  (step_done),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge dbg_clk[0]) ecnt0++;
    always @(posedge dbg_clk[1]) ecnt1++;

    function automatic int unsigned edges(input int ch);
        return (ch == 0) ? ecnt0 : ecnt1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", obs, 32'hFFFF_FFFF);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Present one request for exactly one sampling edge.
    task automatic drive(input logic h, input logic r, input logic s,
                         input logic [NUM_CH-1:0] sel, input logic [STEP_W-1:0] n);
        halt_req   = h;
        resume_req = r;
        step_req   = s;
        ch_sel     = sel;
        step_count = n;
        tick();
        halt_req   = 1'b0;
        resume_req = 1'b0;
        step_req   = 1'b0;
        ch_sel     = '0;
    endtask

    // Step a halted channel and score edges, busy cycles and the completion pulse.
    task automatic run_step(input logic [NUM_CH-1:0] sel, input int ch,
                            input logic [STEP_W-1:0] n, input logic [NUM_CH-1:0] bkpt_mid,
                            input string tag);
        int unsigned e0;
        int unsigned busy_n;
        int unsigned nexp;
        logic        seen;
        nexp = (n == '0) ? 1 : 32'(n);
        sb_push({tag, "_edges"}, nexp);
        sb_push({tag, "_busy"}, nexp);
        sb_push({tag, "_done"}, 1);
        e0 = edges(ch);
        drive(1'b0, 1'b0, 1'b1, sel, n);
        busy_n = 0;
        seen   = 1'b0;
        for (int c = 0; c < int'(nexp) + 10; c++) begin
            if (c == 1 && bkpt_mid != '0) bkpt = bkpt_mid;
            if (busy) busy_n++;
            if (step_done[ch]) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        sb_pop(edges(ch) - e0);
        sb_pop(busy_n);
        sb_pop(32'(seen));
        tick();
        chk({tag, "_done_once"}, 32'(step_done[ch]), 0);
        chk({tag, "_halted"}, 32'(halted[ch]), 1);
    endtask

    initial begin
        int unsigned e0;
        int unsigned e1;
        logic        seen;

        // Reset: all channels run and the gated clocks follow sys_clk.
        repeat (2) tick();
        chk("rst_halted", 32'(halted), 0);
        chk("rst_step_done", 32'(step_done), 0);
        chk("rst_busy", 32'(busy), 0);
        e0 = ecnt0;
        e1 = ecnt1;
        repeat (3) tick();
        chk("rst_edges0", ecnt0 - e0, 3);
        chk("rst_edges1", ecnt1 - e1, 3);
        dbg_rst = 1'b1;
        tick();

        // Unselected request has no effect.
        sb_push("masked_halt", 0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, '0);
        sb_pop(32'(halted));

        // Halt channel 0 only.
        sb_push("halt0_halted", 32'h1);
        drive(1'b1, 1'b0, 1'b0, 2'b01, '0);
        sb_pop(32'(halted));
        e0 = ecnt0;
        e1 = ecnt1;
        repeat (3) tick();
        chk("halt0_edges0", ecnt0 - e0, 0);
        chk("halt0_edges1", ecnt1 - e1, 3);

        // Resume channel 0.
        sb_push("resume0_halted", 0);
        drive(1'b0, 1'b1, 1'b0, 2'b01, '0);
        sb_pop(32'(halted));
        e0 = ecnt0;
        repeat (2) tick();
        chk("resume0_edges", ecnt0 - e0, 2);

        // Halt and step together from RUN, then again from HALT: halt wins.
        drive(1'b1, 1'b0, 1'b1, 2'b01, 8'd3);
        chk("hs_run_halted", 32'(halted), 1);
        chk("hs_run_busy", 32'(busy), 0);
        e0 = ecnt0;
        drive(1'b1, 1'b0, 1'b1, 2'b01, 8'd3);
        chk("hs_halt_busy", 32'(busy), 0);
        repeat (3) tick();
        chk("hs_halt_edges", ecnt0 - e0, 0);
        chk("hs_halt_halted", 32'(halted), 1);

        // Steps of 3, 0 (treated as 1) and the maximum count.
        run_step(2'b01, 0, 8'd3, '0, "step3");
        run_step(2'b01, 0, 8'd0, '0, "step0");
        run_step(2'b01, 0, 8'd255, '0, "step255");

        // Halt during the second cycle of a 5-cycle step aborts without step_done.
        e0 = ecnt0;
        drive(1'b0, 1'b0, 1'b1, 2'b01, 8'd5);
        tick();
        drive(1'b1, 1'b0, 1'b0, 2'b01, '0);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (step_done[0]) seen = 1'b1;
            tick();
        end
        chk("abort_edges", ecnt0 - e0, 2);
        chk("abort_done", 32'(seen), 0);
        chk("abort_halted", 32'(halted), 1);
        chk("abort_busy", 32'(busy), 0);
        drive(1'b0, 1'b1, 1'b0, 2'b01, '0);
        chk("abort_resume", 32'(halted), 0);

        // Breakpoint rising edge on channel 1 halts it.
        bkpt = 2'b10;
        tick();
        chk("bkpt_halted", 32'(halted), 2);
        drive(1'b0, 1'b1, 1'b0, 2'b10, '0);
        e1 = ecnt1;
        repeat (3) tick();
        chk("bkpt_held_halted", 32'(halted), 0);
        chk("bkpt_held_edges", ecnt1 - e1, 3);
        bkpt = 2'b00;
        tick();

        // Breakpoint raised mid-step is ignored.
        drive(1'b1, 1'b0, 1'b0, 2'b10, '0);
        run_step(2'b10, 1, 8'd5, 2'b10, "step_bkpt");
        bkpt = 2'b00;
        drive(1'b0, 1'b1, 1'b0, 2'b10, '0);
        chk("step_bkpt_resume", 32'(halted), 0);

        // Reset during a 10-cycle step returns immediately to RUN.
        drive(1'b1, 1'b0, 1'b0, 2'b01, '0);
        drive(1'b0, 1'b0, 1'b1, 2'b01, 8'd10);
        repeat (2) tick();
        chk("rstmid_busy_pre", 32'(busy), 1);
        dbg_rst = 1'b0;
        #1;
        chk("rstmid_halted", 32'(halted), 0);
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_done", 32'(step_done), 0);
        e0 = ecnt0;
        repeat (2) tick();
        chk("rstmid_edges", ecnt0 - e0, 2);
        dbg_rst = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (step_done != '0) seen = 1'b1;
            tick();
        end
        chk("rstmid_no_done", 32'(seen), 0);

        // First request after release is honoured.
        drive(1'b1, 1'b0, 1'b0, 2'b11, '0);
        chk("post_rst_halt", 32'(halted), 3);

        chk("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
